// File: rtl/tug_round_scorer.sv
// Round scorer at the far end of the tug-of-war light chain.
// Awards points when a player pulls the light off an edge, holds the chain
// in round-reset while it re-centres, and latches the match winner.
module tug_round_scorer #(
  parameter int unsigned SCORE_W     = 3,
  parameter int unsigned MAX_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               L,
  input  logic               R,
  input  logic               leftEndOn,
  input  logic               rightEndOn,
  output logic               roundReset,
  output logic               leftWins,
  output logic               rightWins,
  output logic [SCORE_W-1:0] leftScore,
  output logic [SCORE_W-1:0] rightScore,
  output logic               matchOver,
  output logic               winnerLeft
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] left_score_q, left_score_d;
  logic [SCORE_W-1:0] right_score_q, right_score_d;
  logic               round_reset_q, round_reset_d;
  logic               left_wins_q, left_wins_d;
  logic               right_wins_q, right_wins_d;
  logic               match_over_q, match_over_d;
  logic               winner_left_q, winner_left_d;
  logic               award_left, award_right;

  // State, counter, score and output registers; Reset overrides any point.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= ST_PLAY;
      cnt_q         <= '0;
      left_score_q  <= '0;
      right_score_q <= '0;
      round_reset_q <= 1'b0;
      left_wins_q   <= 1'b0;
      right_wins_q  <= 1'b0;
      match_over_q  <= 1'b0;
      winner_left_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      round_reset_q <= round_reset_d;
      left_wins_q   <= left_wins_d;
      right_wins_q  <= right_wins_d;
      match_over_q  <= match_over_d;
      winner_left_q <= winner_left_d;
    end
  end

  // Next state: point detection in PLAY, hold countdown, DONE is terminal.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    award_left    = 1'b0;
    award_right   = 1'b0;
    case (state_q)
      ST_PLAY: begin
        // L&R together never qualifies, so at most one award per cycle.
        award_left  = leftEndOn & L & ~R;
        award_right = rightEndOn & R & ~L;
        if (award_left && award_right) begin
          award_left  = 1'b0;
          award_right = 1'b0;
        end
        if (award_left) begin
          left_score_d = left_score_q + SCORE_W'(1);
          if (left_score_d == SCORE_MAX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else if (award_right) begin
          right_score_d = right_score_q + SCORE_W'(1);
          if (right_score_d == SCORE_MAX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // Registered output values derived from the upcoming state.
  always_comb begin
    round_reset_d = (state_d != ST_PLAY);
    left_wins_d   = award_left;
    right_wins_d  = award_right;
    match_over_d  = (state_d == ST_DONE);
    winner_left_d = winner_left_q;
    if (state_q == ST_PLAY && state_d == ST_DONE) begin
      winner_left_d = award_left;
    end
  end

  assign roundReset = round_reset_q;
  assign leftWins   = left_wins_q;
  assign rightWins  = right_wins_q;
  assign leftScore  = left_score_q;
  assign rightScore = right_score_q;
  assign matchOver  = match_over_q;
  assign winnerLeft = winner_left_q;

endmodule

// File: tb/tb_tug_round_scorer.sv
// Bench for tug_round_scorer: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance
// share stimulus and are compared against a per-cycle game model.
module tb_tug_round_scorer;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic L = 1'b0, R = 1'b0, leftEndOn = 1'b0, rightEndOn = 1'b0;

  logic       rr4, lw4, rw4, mo4, wl4;
  logic [2:0] ls4, rs4;
  logic       rr1, lw1, rw1, mo1, wl1;
  logic [2:0] ls1, rs1;
  logic [10:0] obs4, obs1;

  int total = 0;
  int bad = 0;

  // Game model, index 0 = HOLD 4 instance, index 1 = HOLD 1 instance.
  int m_ls[2], m_rs[2], m_rem[2];
  bit m_done[2], m_winl[2], m_lw[2], m_rw[2];
  int hold_of[2] = '{4, 1};

  always #5 clk = ~clk;

  tug_round_scorer #(.SCORE_W(3), .MAX_SCORE(7), .HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .Reset(Reset), .L(L), .R(R),
    .leftEndOn(leftEndOn), .rightEndOn(rightEndOn),
    .roundReset(rr4), .leftWins(lw4), .rightWins(rw4),
    .leftScore(ls4), .rightScore(rs4), .matchOver(mo4), .winnerLeft(wl4)
  );

  tug_round_scorer #(.SCORE_W(3), .MAX_SCORE(7), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .Reset(Reset), .L(L), .R(R),
    .leftEndOn(leftEndOn), .rightEndOn(rightEndOn),
    .roundReset(rr1), .leftWins(lw1), .rightWins(rw1),
    .leftScore(ls1), .rightScore(rs1), .matchOver(mo1), .winnerLeft(wl1)
  );

  assign obs4 = {rr4, lw4, rw4, ls4, rs4, mo4, wl4};
  assign obs1 = {rr1, lw1, rw1, ls1, rs1, mo1, wl1};

  // One clock edge of the game: m_rem counts roundReset cycles still owed.
  function automatic void mstep(int i, bit rst, bit l, bit r, bit le, bit re);
    bit lp, rp;
    m_lw[i] = 1'b0;
    m_rw[i] = 1'b0;
    if (rst) begin
      m_ls[i] = 0; m_rs[i] = 0; m_rem[i] = 0; m_done[i] = 1'b0; m_winl[i] = 1'b0;
    end else if (m_done[i]) begin
      // match over: everything frozen
    end else if (m_rem[i] > 0) begin
      m_rem[i] = m_rem[i] - 1;
    end else begin
      lp = le && l && !r;
      rp = re && r && !l;
      if (lp && !rp) begin
        m_ls[i] = m_ls[i] + 1;
        m_lw[i] = 1'b1;
        if (m_ls[i] == 7) begin m_done[i] = 1'b1; m_winl[i] = 1'b1; end
        else m_rem[i] = hold_of[i];
      end else if (rp && !lp) begin
        m_rs[i] = m_rs[i] + 1;
        m_rw[i] = 1'b1;
        if (m_rs[i] == 7) begin m_done[i] = 1'b1; m_winl[i] = 1'b0; end
        else m_rem[i] = hold_of[i];
      end
    end
  endfunction

  function automatic logic [10:0] exp_of(int i);
    logic rr_e;
    rr_e = m_done[i] || (m_rem[i] > 0);
    return {rr_e, m_lw[i], m_rw[i], 3'(m_ls[i]), 3'(m_rs[i]), m_done[i], m_winl[i]};
  endfunction

  // Apply one cycle of inputs, advance both models, sample 1 time unit after the edge.
  task automatic step(input bit rst, input bit l, input bit r, input bit le, input bit re);
    Reset = rst; L = l; R = r; leftEndOn = le; rightEndOn = re;
    @(posedge clk);
    #1;
    mstep(0, rst, l, r, le, re);
    mstep(1, rst, l, r, le, re);
    Reset = 1'b0; L = 1'b0; R = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
    total++;
    if (obs4 !== 11'h000) begin bad++; $display("FAIL reset_dut4 got=%h want=%h", obs4, 11'h000); end
    total++;
    if (obs1 !== 11'h000) begin bad++; $display("FAIL reset_dut1 got=%h want=%h", obs1, 11'h000); end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 0, 0);
      total++;
      if (obs4 !== exp_of(0)) begin bad++; $display("FAIL idle got=%h want=%h", obs4, exp_of(0)); end
    end
    step(0, 1, 0, 0, 0);
    total++;
    if ({ls4, rs4, lw4} !== 7'd0) begin bad++; $display("FAIL press_unlit got=%h want=%h", {ls4, rs4, lw4}, 7'd0); end
  endtask

  task automatic test_right_point();
    int n;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    total++;
    if ({rw4, rs4, rr4} !== {1'b1, 3'd1, 1'b1}) begin
      bad++; $display("FAIL right_point got=%b want=%b", {rw4, rs4, rr4}, {1'b1, 3'd1, 1'b1});
    end
    n = 1;
    for (int j = 0; j < 7; j++) begin
      step(0, 0, (j < 4), 0, 1);
      if (rr4) n++;
      total++;
      if (obs4 !== exp_of(0)) begin bad++; $display("FAIL right_hold4 got=%h want=%h", obs4, exp_of(0)); end
      total++;
      if (obs1 !== exp_of(1)) begin bad++; $display("FAIL right_hold1 got=%h want=%h", obs1, exp_of(1)); end
    end
    total++;
    if (n !== 4) begin bad++; $display("FAIL rr_width got=%0d want=%0d", n, 4); end
    total++;
    if (rs4 !== 3'd1) begin bad++; $display("FAIL hold_ignored got=%0d want=%0d", rs4, 1); end
  endtask

  task automatic test_both_ends();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    total++;
    if ({lw4, ls4} !== {1'b1, 3'd1}) begin bad++; $display("FAIL both_left got=%b want=%b", {lw4, ls4}, 4'b1001); end
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    total++;
    if ({rw4, rs4} !== {1'b1, 3'd1}) begin bad++; $display("FAIL both_right got=%b want=%b", {rw4, rs4}, 4'b1001); end
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
    step(0, 1, 1, 1, 1);
    total++;
    if ({lw4, rw4, ls4, rs4, rr4} !== {2'b00, 3'd1, 3'd1, 1'b0}) begin
      bad++; $display("FAIL both_lr got=%b want=%b", {lw4, rw4, ls4, rs4, rr4}, {2'b00, 3'd1, 3'd1, 1'b0});
    end
    total++;
    if (obs1 !== exp_of(1)) begin bad++; $display("FAIL both_dut1 got=%h want=%h", obs1, exp_of(1)); end
  endtask

  task automatic test_match();
    step(1, 0, 0, 0, 0);
    for (int p = 0; p < 7; p++) begin
      step(0, 0, 1, 0, 1);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
    end
    total++;
    if ({rs4, mo4, wl4, rr4} !== {3'd7, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL match_right got=%b want=%b", {rs4, mo4, wl4, rr4}, {3'd7, 3'b101});
    end
    for (int k = 0; k < 4; k++) begin
      step(0, k[0], !k[0], 1, 1);
      total++;
      if (obs4 !== exp_of(0)) begin bad++; $display("FAIL done_frozen got=%h want=%h", obs4, exp_of(0)); end
    end
    total++;
    if (obs1 !== exp_of(1)) begin bad++; $display("FAIL match_dut1 got=%h want=%h", obs1, exp_of(1)); end
    step(1, 0, 0, 0, 0);
    for (int p = 0; p < 7; p++) begin
      step(0, 1, 0, 1, 0);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
    end
    total++;
    if ({ls4, mo4, wl4} !== {3'd7, 1'b1, 1'b1}) begin
      bad++; $display("FAIL match_left got=%b want=%b", {ls4, mo4, wl4}, 5'b11111);
    end
  endtask

  task automatic test_reset_priority();
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    total++;
    if ({ls4, lw4, rr4} !== 5'd0) begin bad++; $display("FAIL reset_vs_point got=%b want=%b", {ls4, lw4, rr4}, 5'd0); end
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    total++;
    if ({rr4, ls4} !== {1'b1, 3'd1}) begin bad++; $display("FAIL hold_second got=%b want=%b", {rr4, ls4}, 4'b1001); end
    step(1, 0, 0, 1, 0);
    total++;
    if (obs4 !== 11'h000) begin bad++; $display("FAIL reset_mid_hold got=%h want=%h", obs4, 11'h000); end
    step(0, 1, 0, 1, 0);
    total++;
    if ({lw4, ls4} !== {1'b1, 3'd1}) begin bad++; $display("FAIL play_after_reset got=%b want=%b", {lw4, ls4}, 4'b1001); end
  endtask

  task automatic test_hold1();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    total++;
    if ({rr1, rw1, rs1} !== {2'b11, 3'd1}) begin bad++; $display("FAIL h1_point got=%b want=%b", {rr1, rw1, rs1}, 5'b11001); end
    step(0, 0, 0, 0, 1);
    total++;
    if ({rr1, rw1} !== 2'b00) begin bad++; $display("FAIL h1_rr_pulse got=%b want=%b", {rr1, rw1}, 2'b00); end
    step(0, 0, 1, 0, 1);
    total++;
    if ({rw1, rs1} !== {1'b1, 3'd2}) begin bad++; $display("FAIL h1_next_press got=%b want=%b", {rw1, rs1}, 4'b1010); end
  endtask

  task automatic test_random();
    bit rst, l, r, le, re;
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      l   = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 2) == 0);
      le  = ($urandom_range(0, 1) == 0);
      re  = ($urandom_range(0, 1) == 0);
      step(rst, l, r, le, re);
      total++;
      if (obs4 !== exp_of(0)) begin bad++; $display("FAIL rand4 cyc=%0d got=%h want=%h", c, obs4, exp_of(0)); end
      total++;
      if (obs1 !== exp_of(1)) begin bad++; $display("FAIL rand1 cyc=%0d got=%h want=%h", c, obs1, exp_of(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_right_point();
    test_both_ends();
    test_match();
    test_reset_priority();
    test_hold1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tug_round_scorer.md
Name: tug_round_scorer

Overview:
Reader at the far end of the tug-of-war light chain. It consumes the two end-light states and the L/R press pulses and detects when a player pulls the light off an edge. It awards the point, keeps per-player scores and drives the round-reset that re-centres the light chain. It also declares the match winner once a score reaches the target.

Parameters:
SCORE_W, 3, width of each score counter
MAX_SCORE, 7, score that ends the match (1..2^SCORE_W-1)
HOLD_CYCLES, 4, cycles roundReset stays high after a point (>=1)

Ports:
clk  input  1  system clock, all state on posedge
Reset  input  1  synchronous, active-high reset
L  input  1  left-player press, one-cycle pulse, already conditioned
R  input  1  right-player press, one-cycle pulse, already conditioned
leftEndOn  input  1  leftmost light of chain is lit
rightEndOn  input  1  rightmost light of chain is lit
roundReset  output  1  re-centre request to light chain (ORed into its Reset)
leftWins  output  1  one-cycle pulse: point to left player
rightWins  output  1  one-cycle pulse: point to right player
leftScore  output  SCORE_W  left player score
rightScore  output  SCORE_W  right player score
matchOver  output  1  match finished, sticky until Reset
winnerLeft  output  1  valid when matchOver: 1 = left won, 0 = right won

Behaviour:
- Interface: one clock (clk); reset (Reset) is synchronous and active-high.
- Reset values: state PLAY, hold counter 0. All of roundReset, leftWins, rightWins, leftScore, rightScore, matchOver, winnerLeft are 0.
- Reset has priority over every other event, including a point in the same cycle.
- Reset asserted during HOLD or DONE returns the block to PLAY with scores cleared.
- Win conditions, evaluated only in PLAY:
  - Right point: rightEndOn & R & ~L.
  - Left point: leftEndOn & L & ~R.
  - Both true in the same cycle (illegal: both ends lit) -> no point, stay in PLAY.
  - L&R together -> never a point, since the chain does not move.
- States:
  - PLAY: on a point at edge k, the awarding player's score increments at edge k.
    - The matching win pulse is high for exactly one cycle (edge k to edge k+1).
    - If the new score == MAX_SCORE -> DONE. Otherwise -> HOLD, with the counter loaded to HOLD_CYCLES-1.
  - HOLD: roundReset = 1 and all inputs are ignored.
    - While counter != 0 it decrements.
    - When counter == 0 -> PLAY at the next edge.
    - roundReset is therefore high for exactly HOLD_CYCLES cycles, starting in the same cycle as the win pulse.
  - DONE: matchOver = 1, roundReset = 1 (held), scores frozen, all inputs ignored.
    - winnerLeft is set at entry and held.
    - Exits only via Reset.
- Outputs: all are registered, with no combinational path from inputs to outputs. roundReset is 0 in PLAY.
- Scores: unsigned and saturating by construction. They never exceed MAX_SCORE, and no wrap-around is possible because DONE freezes them.
- A press in the first PLAY cycle after HOLD is evaluated normally.

Test Plan:
- Reset 3 cycles, then idle -> all outputs 0, state PLAY. L=1,R=0 with leftEndOn=0 -> no point, scores 0/0.
- rightEndOn=1, R pulse with L=0 -> rightWins high 1 cycle, rightScore=1, roundReset high exactly 4 cycles. Any R pulse during those 4 cycles is ignored, so rightScore stays 1.
- leftEndOn=1 and rightEndOn=1, L=1,R=0 in one cycle and L=0,R=1 in another -> leftScore=1 and rightScore=1 respectively. L=1,R=1 with both ends lit -> no point in any case.
- Seven right points, each separated by full HOLD -> after the 7th, rightScore=7, matchOver=1, winnerLeft=0, roundReset stuck at 1. Further presses -> no change.
- Left point occurring in the same cycle as Reset=1 -> leftScore=0, leftWins=0. Reset mid-HOLD (2nd hold cycle) -> roundReset=0 next cycle, scores 0, PLAY.
- HOLD_CYCLES=1 build: a point gives a roundReset pulse of exactly 1 cycle, and a press in the cycle right after is scored.
